// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data memory bank.
package data_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } mem_state_t;

  // Clear pointer width: enough bits to hold DEPTH-1, never less than one.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_clear_seq.sv
// Clear sequencer: walks the array from word 0 to DEPTH-1, one word per cycle,
// after reset or an accepted clear request.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_CLEAR | pointer writes zero to one word per cycle
// ST_IDLE  | array available for normal reads and writes
module data_mem_clear_seq
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_req,
  output logic             clr_we,
  output logic [PTR_W-1:0] clr_addr,
  output logic             done,
  output logic             busy
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  mem_state_t       state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;

  // State and pointer register; reset restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state: clear ends on the edge that writes the last word, no wrap.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_CLEAR: begin
        if (ptr == LAST) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + PTR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr;
  assign done     = busy && (ptr == LAST);

endmodule

// File: rtl/data_mem_bank.sv
// Single-clock data memory: one write port, two registered read ports,
// hardware clear sequencer and out-of-range flagging.
// Optional feature macro: DATA_MEM_BANK_BYPASS_EN (write-first forwarding on
// same-address read/write; default build is read-first).
module data_mem_bank
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd0_valid,
  output logic              rd1_valid,
  output logic              busy,
  output logic              err_oob
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic             clr_we;
  logic [PTR_W-1:0] clr_addr;
  logic             done;
  logic             unused_done;

  // Terminal-count flag is not needed here beyond the sequencer itself.
  assign unused_done = done;

  data_mem_clear_seq #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .done      (done),
    .busy      (busy)
  );

  // Addresses are compared unsigned against DEPTH; DEPTH may equal 2^ADDR_W.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  logic idle;
  logic wr_req, wr_in, wr_ok, wr_oob;
  logic rd0_fire, rd1_fire, rd0_in, rd1_in;
  logic [DATA_W-1:0] rd0_word, rd1_word;

  assign idle     = !busy;
  // A clear request drops a same-cycle write without flagging it.
  assign wr_req   = idle && wr_en && !clear_req;
  assign wr_in    = in_range(wr_addr);
  assign wr_ok    = wr_req && wr_in;
  assign wr_oob   = wr_req && !wr_in;
  // Reads alongside a clear request still see the pre-clear contents.
  assign rd0_fire = idle && rd0_en;
  assign rd1_fire = idle && rd1_en;
  assign rd0_in   = in_range(rd0_addr);
  assign rd1_in   = in_range(rd1_addr);

  // Read word selection, with optional write-first forwarding; out-of-range gives 0.
  always_comb begin
    rd0_word = mem[rd0_addr[PTR_W-1:0]];
    rd1_word = mem[rd1_addr[PTR_W-1:0]];
`ifdef DATA_MEM_BANK_BYPASS_EN
    if (wr_ok && (wr_addr == rd0_addr)) rd0_word = wr_data;
    if (wr_ok && (wr_addr == rd1_addr)) rd1_word = wr_data;
`endif
    if (!rd0_in) rd0_word = '0;
    if (!rd1_in) rd1_word = '0;
  end

  // Array update: the clear sweep owns the array while busy; it has no reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr[PTR_W-1:0]] <= wr_data;
    end
  end

  // Read registers, valid pulses and out-of-range error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd0_data  <= '0;
      rd1_data  <= '0;
      rd0_valid <= 1'b0;
      rd1_valid <= 1'b0;
      err_oob   <= 1'b0;
    end else begin
      rd0_valid <= rd0_fire;
      rd1_valid <= rd1_fire;
      if (rd0_fire) rd0_data <= rd0_word;
      if (rd1_fire) rd1_data <= rd1_word;
      err_oob <= wr_oob || (rd0_fire && !rd0_in) || (rd1_fire && !rd1_in);
    end
  end

endmodule
